// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle MIPS control FSM with memory-ready handshake and optional watchdog.
// Define MC_CTRL_JAL_EN to enable the JAL state (opcode 0x03); otherwise 0x03 is illegal.
module mips_mc_control #(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  pc_write_cond,
    output logic                  pc_write_cond_ne,
    output logic                  i_or_d,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic [1:0]            reg_dst,
    output logic [1:0]            mem_to_reg,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic                  ext_type,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            pc_source,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  illegal_op,
    output logic                  mem_timeout,
    output logic [3:0]            state
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4,
        MEM_WR = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7, I_EXEC = 4'd8, I_WB = 4'd9,
        BRANCH = 4'd10, JUMP = 4'd11, JAL = 4'd12
    } state_t;
    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100;
    localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
    state_t st, nx;
    logic [CW-1:0] cnt;
    logic [3:0] r_alu, alu4;
    logic r_ok, dec_ill, wait_st, timeout;
    assign state = st;
    assign wait_st = st == FETCH || st == MEM_RD || st == MEM_WR;
    assign timeout = MEM_TIMEOUT > 0 && wait_st && !mem_ready && cnt == CW'(MEM_TIMEOUT - 1);
    assign alu_ctrl = ALU_CTRL_W'(alu4);
    always_comb begin
        r_ok = 1'b1;
        r_alu = ALU_ADD;
        case (funct)
            6'h20: r_alu = ALU_ADD;
            6'h22: r_alu = ALU_SUB;
            6'h24: r_alu = ALU_AND;
            6'h25: r_alu = ALU_OR;
            6'h27: r_alu = ALU_NOR;
            6'h2A: r_alu = ALU_SLT;
            default: r_ok = 1'b0;
        endcase
    end
    always_ff @(posedge clk) begin
        st <= rst ? FETCH : nx;
        cnt <= (rst || !wait_st || mem_ready || timeout) ? '0 : cnt + 1'b1;
        illegal_op <= !rst && dec_ill;
        mem_timeout <= !rst && timeout;
    end
    always_comb begin
        nx = FETCH;
        dec_ill = 1'b0;
        case (st)
            FETCH:    nx = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    6'h00: nx = R_EXEC;
                    6'h23, 6'h2B: nx = MEM_ADDR;
                    6'h04, 6'h05: nx = BRANCH;
                    6'h02: nx = JUMP;
`ifdef MC_CTRL_JAL_EN
                    6'h03: nx = JAL;
`endif
                    6'h08, 6'h0C, 6'h0D, 6'h0A: nx = I_EXEC;
                    default: dec_ill = 1'b1;
                endcase
            end
            MEM_ADDR: nx = opcode == 6'h23 ? MEM_RD : MEM_WR;
            MEM_RD:   nx = mem_ready ? MEM_WB : timeout ? FETCH : MEM_RD;
            MEM_WR:   nx = (mem_ready || timeout) ? FETCH : MEM_WR;
            R_EXEC: begin
                nx = r_ok ? R_WB : FETCH;
                dec_ill = !r_ok;
            end
            I_EXEC:   nx = I_WB;
            default:  nx = FETCH;
        endcase
    end
    always_comb begin
        pc_write = 1'b0;
        pc_write_cond = 1'b0;
        pc_write_cond_ne = 1'b0;
        i_or_d = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        ir_write = 1'b0;
        reg_dst = 2'd0;
        mem_to_reg = 2'd0;
        reg_write = 1'b0;
        alu_src_a = 1'b0;
        ext_type = 1'b1;
        alu_src_b = 2'd0;
        pc_source = 2'd0;
        alu4 = ALU_ADD;
        case (st)
            FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
                alu_src_b = 2'd1;
            end
            DECODE: alu_src_b = 2'd3;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            MEM_RD: begin
                i_or_d = 1'b1;
                mem_read = 1'b1;
            end
            MEM_WB: begin
                mem_to_reg = 2'd1;
                reg_write = 1'b1;
            end
            MEM_WR: begin
                i_or_d = 1'b1;
                mem_write = 1'b1;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu4 = r_alu;
            end
            R_WB: begin
                reg_dst = 2'd1;
                reg_write = 1'b1;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu4 = opcode == 6'h0A ? ALU_SLT : opcode == 6'h0C ? ALU_AND : opcode == 6'h0D ? ALU_OR : ALU_ADD;
                ext_type = !(opcode == 6'h0C || opcode == 6'h0D);
            end
            I_WB: reg_write = 1'b1;
            BRANCH: begin
                alu_src_a = 1'b1;
                alu4 = ALU_SUB;
                pc_source = 2'd1;
                pc_write_cond = opcode == 6'h04;
                pc_write_cond_ne = opcode == 6'h05;
            end
            JUMP: begin
                pc_source = 2'd2;
                pc_write = 1'b1;
            end
`ifdef MC_CTRL_JAL_EN
            JAL: begin
                pc_source = 2'd2;
                pc_write = 1'b1;
                reg_dst = 2'd2;
                mem_to_reg = 2'd2;
                reg_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: directed checks of the multi-cycle control FSM (watchdog set to 4 cycles).
module tb_mips_mc_control;
    logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b1;
    logic [5:0] opcode = 6'h00, funct = 6'h00;
    logic pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read, mem_write, ir_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic reg_write, alu_src_a, ext_type, illegal_op, mem_timeout;
    logic [3:0] alu_ctrl, state;
    int total = 0, passed = 0, cyc = 0;

    mips_mc_control #(.ALU_CTRL_W(4), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_write_cond_ne(pc_write_cond_ne),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .ext_type(ext_type), .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_ctrl(alu_ctrl),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_mem_read", 32'(mem_read), 1);
        chk("rst_pc_write", 32'(pc_write), 1);
        chk("rst_reg_write", 32'(reg_write), 0);
        chk("rst_alu_src_b", 32'(alu_src_b), 1);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 4'b0010);
        chk("rst_ext_type", 32'(ext_type), 1);
        chk("rst_illegal", 32'(illegal_op), 0);
        rst = 1'b0;
        // R-type sub
        opcode = 6'h00; funct = 6'h22; cyc = 0;
        chk("r_fetch_ir_write", 32'(ir_write), 1);
        tick();
        chk("r_decode", 32'(state), 1);
        chk("r_decode_srcb", 32'(alu_src_b), 3);
        tick();
        chk("r_exec", 32'(state), 6);
        chk("r_exec_alu", 32'(alu_ctrl), 4'b0110);
        chk("r_exec_srca", 32'(alu_src_a), 1);
        chk("r_exec_no_wr", 32'(reg_write), 0);
        tick();
        chk("r_wb", 32'(state), 7);
        chk("r_wb_reg_write", 32'(reg_write), 1);
        chk("r_wb_reg_dst", 32'(reg_dst), 1);
        tick();
        chk("r_done", 32'(state), 0);
        chk("r_cycles", 32'(cyc), 4);
        // lw with 3 wait cycles
        opcode = 6'h23; cyc = 0;
        tick();
        tick();
        chk("lw_addr", 32'(state), 2);
        chk("lw_addr_srcb", 32'(alu_src_b), 2);
        mem_ready = 1'b0;
        tick();
        chk("lw_rd", 32'(state), 3);
        chk("lw_rd_iord", 32'(i_or_d), 1);
        chk("lw_rd_mem_read", 32'(mem_read), 1);
        repeat (3) tick();
        chk("lw_rd_hold", 32'(state), 3);
        mem_ready = 1'b1;
        tick();
        chk("lw_wb", 32'(state), 4);
        chk("lw_wb_reg_write", 32'(reg_write), 1);
        chk("lw_wb_mem_to_reg", 32'(mem_to_reg), 1);
        chk("lw_no_timeout", 32'(mem_timeout), 0);
        tick();
        chk("lw_done", 32'(state), 0);
        chk("lw_cycles", 32'(cyc), 8);
        // bne
        opcode = 6'h05; cyc = 0;
        tick();
        tick();
        chk("bne_state", 32'(state), 10);
        chk("bne_cond_ne", 32'(pc_write_cond_ne), 1);
        chk("bne_cond", 32'(pc_write_cond), 0);
        chk("bne_pc_source", 32'(pc_source), 1);
        chk("bne_alu", 32'(alu_ctrl), 4'b0110);
        tick();
        chk("bne_done", 32'(state), 0);
        chk("bne_cycles", 32'(cyc), 3);
        // ori
        opcode = 6'h0D;
        tick();
        tick();
        chk("ori_exec", 32'(state), 8);
        chk("ori_alu", 32'(alu_ctrl), 4'b0001);
        chk("ori_ext", 32'(ext_type), 0);
        tick();
        chk("ori_wb", 32'(state), 9);
        chk("ori_wb_reg_write", 32'(reg_write), 1);
        tick();
        // jump
        opcode = 6'h02;
        tick();
        tick();
        chk("j_state", 32'(state), 11);
        chk("j_pc_write", 32'(pc_write), 1);
        chk("j_pc_source", 32'(pc_source), 2);
        tick();
        chk("j_done", 32'(state), 0);
        // sw with memory stuck: watchdog fires after 4 wait cycles
        opcode = 6'h2B;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk("sw_wr", 32'(state), 5);
        chk("sw_mem_write", 32'(mem_write), 1);
        repeat (3) tick();
        chk("sw_wr_hold", 32'(state), 5);
        chk("sw_no_timeout_yet", 32'(mem_timeout), 0);
        tick();
        chk("sw_to_fetch", 32'(state), 0);
        chk("sw_timeout_pulse", 32'(mem_timeout), 1);
        chk("sw_mem_write_off", 32'(mem_write), 0);
        chk("fetch_wait_pc_write", 32'(pc_write), 0);
        tick();
        chk("sw_timeout_single", 32'(mem_timeout), 0);
        mem_ready = 1'b1;
        #1;
        chk("fetch_ready_pc_write", 32'(pc_write), 1);
        // illegal opcode 0x3F
        opcode = 6'h3F;
        tick();
        tick();
        chk("ill3f_state", 32'(state), 0);
        chk("ill3f_pulse", 32'(illegal_op), 1);
        chk("ill3f_no_wr", 32'(reg_write), 0);
        opcode = 6'h03;
        tick();
        chk("ill_pulse_end", 32'(illegal_op), 0);
        tick();
`ifdef MC_CTRL_JAL_EN
        chk("jal_state", 32'(state), 12);
        chk("jal_reg_dst", 32'(reg_dst), 2);
        chk("jal_mem_to_reg", 32'(mem_to_reg), 2);
        chk("jal_reg_write", 32'(reg_write), 1);
        chk("jal_pc_write", 32'(pc_write), 1);
        tick();
        chk("jal_done", 32'(state), 0);
`else
        chk("ill03_state", 32'(state), 0);
        chk("ill03_pulse", 32'(illegal_op), 1);
        chk("ill03_no_wr", 32'(reg_write), 0);
`endif
        // unknown funct
        opcode = 6'h00; funct = 6'h3F;
        tick();
        tick();
        chk("badf_exec", 32'(state), 6);
        tick();
        chk("badf_state", 32'(state), 0);
        chk("badf_pulse", 32'(illegal_op), 1);
        chk("badf_no_wr", 32'(reg_write), 0);
        // reset mid-instruction
        funct = 6'h20;
        tick();
        tick();
        chk("abort_exec", 32'(state), 6);
        chk("abort_add", 32'(alu_ctrl), 4'b0010);
        rst = 1'b1;
        tick();
        chk("abort_state", 32'(state), 0);
        chk("abort_no_wr", 32'(reg_write), 0);
        rst = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
